// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - binary32 field widths, constants and operand classification
// Purpose: shared definitions for the single-precision multiplier.
// Ports: none (package).
package fp32_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;

  localparam logic [31:0]      QNAN    = 32'h7FC00000;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    ZERO,
    NORMAL,
    INF,
    NAN
  } fp_class_e;

  // Denormals (exp=0, frac!=0) classify as ZERO: they are flushed before use.
  function automatic fp_class_e classify(input logic [31:0] x);
    logic [EXP_W-1:0]  exp_f;
    logic [FRAC_W-1:0] frac_f;
    exp_f  = x[FRAC_W +: EXP_W];
    frac_f = x[FRAC_W-1:0];
    if (exp_f == EXP_MAX) begin
      return (frac_f != '0) ? NAN : INF;
    end else if (exp_f == '0) begin
      return ZERO;
    end
    return NORMAL;
  endfunction

endpackage

// File: rtl/fp32_round_pack.sv
// rtl/fp32_round_pack.sv - normalise, round-to-nearest-even, range check and pack
// Purpose: pipeline stages S3 (normalise) and S4 (round/pack) of the multiplier.
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   i_prod         48-bit product of the two 24-bit significands
//   i_exp          biased exponent ea+eb-BIAS (signed)
//   i_sign         result sign
//   i_special      result is taken verbatim from i_special_val
//   i_special_val  NaN/Inf/zero result decided at unpack
//   o_z            packed binary32 result (registered)
module fp32_round_pack
  import fp32_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [47:0]        i_prod,
  input  logic signed [9:0]  i_exp,
  input  logic               i_sign,
  input  logic               i_special,
  input  logic [31:0]        i_special_val,
  output logic [31:0]        o_z
);

  // S3: put the leading one at bit 47. A product in [2,4) already has it
  // there and gains one exponent; a product in [1,2) is shifted left so no
  // low bits are lost from the sticky computation.
  logic [47:0]       w_norm;
  logic signed [9:0] w_exp_n;

  assign w_norm  = i_prod[47] ? i_prod : {i_prod[46:0], 1'b0};
  assign w_exp_n = i_prod[47] ? (i_exp + 10'sd1) : i_exp;

  logic [23:0]       r3_mant;
  logic              r3_guard;
  logic              r3_round;
  logic              r3_sticky;
  logic signed [9:0] r3_exp;
  logic              r3_sign;
  logic              r3_special;
  logic [31:0]       r3_special_val;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r3_mant        <= '0;
      r3_guard       <= 1'b0;
      r3_round       <= 1'b0;
      r3_sticky      <= 1'b0;
      r3_exp         <= '0;
      r3_sign        <= 1'b0;
      r3_special     <= 1'b0;
      r3_special_val <= '0;
    end else begin
      r3_mant        <= w_norm[47:24];
      r3_guard       <= w_norm[23];
      r3_round       <= w_norm[22];
      r3_sticky      <= |w_norm[21:0];
      r3_exp         <= w_exp_n;
      r3_sign        <= i_sign;
      r3_special     <= i_special;
      r3_special_val <= i_special_val;
    end
  end

  // S4: RNE rounds up above half, or at exactly half when the kept LSB is odd.
  logic              w_round_up;
  logic [24:0]       w_mant_r;
  logic signed [9:0] w_exp_r;
  logic [FRAC_W-1:0] w_frac;
  logic [31:0]       w_z;

  assign w_round_up = r3_guard & (r3_round | r3_sticky | r3_mant[0]);
  assign w_mant_r   = {1'b0, r3_mant} + {24'h0, w_round_up};
  // Carry-out means the mantissa rolled over to 10.000...; renormalise.
  assign w_exp_r    = w_mant_r[24] ? (r3_exp + 10'sd1) : r3_exp;
  assign w_frac     = w_mant_r[24] ? w_mant_r[23:1] : w_mant_r[22:0];

  always_comb begin
    w_z = {r3_sign, w_exp_r[EXP_W-1:0], w_frac};
    if (r3_special) begin
      w_z = r3_special_val;
    end else if (w_exp_r >= 10'sd255) begin
      w_z = {r3_sign, EXP_MAX, {FRAC_W{1'b0}}};
    end else if (w_exp_r <= 10'sd0) begin
      w_z = {r3_sign, 31'h0};
    end
  end

  logic [31:0] r_z;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_z <= '0;
    end else begin
      r_z <= w_z;
    end
  end

  assign o_z = r_z;

endmodule

// File: rtl/float_multi.sv
// rtl/float_multi.sv - 4-stage pipelined binary32 multiplier, z = a * b
// Purpose: S1 unpack/classify, S2 significand multiply, S3/S4 in fp32_round_pack.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset, clears every pipeline stage
//   a    operand A, binary32, sampled every cycle
//   b    operand B, binary32, sampled every cycle
//   z    product, binary32, registered, 4 cycles after its operands
module float_multi
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] z
);

  // S1: unpack and classify.
  fp_class_e         w_cls_a;
  fp_class_e         w_cls_b;
  logic              w_sign;
  logic              w_special;
  logic [31:0]       w_special_val;
  logic signed [9:0] w_exp;

  assign w_cls_a   = classify(a);
  assign w_cls_b   = classify(b);
  assign w_sign    = a[31] ^ b[31];
  assign w_special = (w_cls_a != NORMAL) || (w_cls_b != NORMAL);
  assign w_exp     = signed'({2'b00, a[FRAC_W +: EXP_W]})
                   + signed'({2'b00, b[FRAC_W +: EXP_W]})
                   - 10'(BIAS);

  // Priority NaN > Inf > zero; Inf*0 deliberately yields Inf.
  always_comb begin
    w_special_val = {w_sign, 31'h0};
    if (w_cls_a == NAN || w_cls_b == NAN) begin
      w_special_val = QNAN;
    end else if (w_cls_a == INF || w_cls_b == INF) begin
      w_special_val = {w_sign, EXP_MAX, {FRAC_W{1'b0}}};
    end
  end

  logic              r1_sign;
  logic              r1_special;
  logic [31:0]       r1_special_val;
  logic [23:0]       r1_ma;
  logic [23:0]       r1_mb;
  logic signed [9:0] r1_exp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r1_sign        <= 1'b0;
      r1_special     <= 1'b0;
      r1_special_val <= '0;
      r1_ma          <= '0;
      r1_mb          <= '0;
      r1_exp         <= '0;
    end else begin
      r1_sign        <= w_sign;
      r1_special     <= w_special;
      r1_special_val <= w_special_val;
      r1_ma          <= {1'b1, a[FRAC_W-1:0]};
      r1_mb          <= {1'b1, b[FRAC_W-1:0]};
      r1_exp         <= w_exp;
    end
  end

  // S2: 24x24 significand multiply.
  logic [47:0]       r2_prod;
  logic signed [9:0] r2_exp;
  logic              r2_sign;
  logic              r2_special;
  logic [31:0]       r2_special_val;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r2_prod        <= '0;
      r2_exp         <= '0;
      r2_sign        <= 1'b0;
      r2_special     <= 1'b0;
      r2_special_val <= '0;
    end else begin
      r2_prod        <= {24'h0, r1_ma} * {24'h0, r1_mb};
      r2_exp         <= r1_exp;
      r2_sign        <= r1_sign;
      r2_special     <= r1_special;
      r2_special_val <= r1_special_val;
    end
  end

  fp32_round_pack u_round_pack (
    .clk           (clk),
    .rst           (rst),
    .i_prod        (r2_prod),
    .i_exp         (r2_exp),
    .i_sign        (r2_sign),
    .i_special     (r2_special),
    .i_special_val (r2_special_val),
    .o_z           (z)
  );

endmodule

// File: tb/tb_float_multi.sv
// tb/tb_float_multi.sv - directed self-checking bench for float_multi
module tb_float_multi;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] z;

  int checks = 0;
  int errors = 0;

  float_multi dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .z   (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a pair, hold it, check the result after the 4th rising edge.
  task automatic held(input logic [31:0] va, input logic [31:0] vb,
                      input logic [31:0] vz, input string tag);
    a = va;
    b = vb;
    repeat (4) @(posedge clk);
    #1;
    chk(z, vz, tag);
  endtask

  localparam int N = 10;
  logic [31:0] pa [N];
  logic [31:0] pb [N];
  logic [31:0] pz [N];

  initial begin
    pa[0] = 32'h3F800000; pb[0] = 32'h3F800000; pz[0] = 32'h3F800000;
    pa[1] = 32'hC0000000; pb[1] = 32'h40400000; pz[1] = 32'hC0C00000;
    pa[2] = 32'h40000000; pb[2] = 32'h40000000; pz[2] = 32'h40800000;
    pa[3] = 32'h3FC00000; pb[3] = 32'h3FC00000; pz[3] = 32'h40100000;
    pa[4] = 32'h7F800000; pb[4] = 32'h80000000; pz[4] = 32'hFF800000;
    pa[5] = 32'h3E99999A; pb[5] = 32'h3E99999A; pz[5] = 32'h3DB851EC;
    pa[6] = 32'h80400000; pb[6] = 32'h3F800000; pz[6] = 32'h80000000;
    pa[7] = 32'h7F000000; pb[7] = 32'h40000000; pz[7] = 32'h7F800000;
    pa[8] = 32'h3F800001; pb[8] = 32'h3FC00000; pz[8] = 32'h3FC00002;
    pa[9] = 32'hFFC00000; pb[9] = 32'h00000000; pz[9] = 32'h7FC00000;

    rst = 1'b0;
    a   = 32'h3F800000;
    b   = 32'h40000000;
    #1;
    chk(z, 32'h0, "reset_initial");
    repeat (3) @(posedge clk);
    #1;
    chk(z, 32'h0, "reset_held");
    rst = 1'b1;

    held(32'h3E99999A, 32'h3E99999A, 32'h3DB851EC, "mul_0p3_0p3");
    @(posedge clk); #1;
    chk(z, 32'h3DB851EC, "hold_constant");
    held(32'h7F800000, 32'h00000000, 32'h7F800000, "inf_times_zero");
    held(32'h7F800000, 32'h7F800000, 32'h7F800000, "inf_times_inf");
    held(32'h7FC00000, 32'h3E000000, 32'h7FC00000, "nan_times_valid");
    held(32'hC0000000, 32'h40400000, 32'hC0C00000, "neg2_times_3");
    held(32'h7F000000, 32'h7F000000, 32'h7F800000, "overflow");
    held(32'h00800000, 32'h00800000, 32'h00000000, "underflow");
    held(32'h00800000, 32'h3F000000, 32'h00000000, "underflow_exp0");
    held(32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, "max_normal");
    held(32'h3F800001, 32'h3FC00000, 32'h3FC00002, "rne_tie_up");
    held(32'h3F800003, 32'h3FC00000, 32'h3FC00004, "rne_tie_even");
    held(32'h3F800001, 32'h3FFFFFFE, 32'h40000000, "round_carry_out");
    held(32'h00400000, 32'h7F000000, 32'h00000000, "denormal_flush");

    // Mid-cycle asynchronous reset with a nonzero result in flight.
    held(32'h3F800000, 32'h3F800000, 32'h3F800000, "pre_reset");
    #2;
    rst = 1'b0;
    #1;
    chk(z, 32'h0, "reset_async");
    @(posedge clk); #1;
    chk(z, 32'h0, "reset_edge");
    rst = 1'b1;

    // Back-to-back distinct operands: result i appears after edge i+4.
    for (int i = 0; i < N + 3; i++) begin
      if (i < N) begin
        a = pa[i];
        b = pb[i];
      end
      @(posedge clk);
      #1;
      if (i >= 3) begin
        chk(z, pz[i-3], $sformatf("pipe%0d", i - 3));
      end else begin
        chk(z, 32'h0, $sformatf("pipe_fill%0d", i));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/float_multi.md
Name: float_multi

Overview:
- Single-precision (IEEE-754 binary32) floating-point multiplier: z = a * b.
- Fully pipelined, fixed latency of 4 clock cycles, accepts a new operand pair every cycle.
- No handshake.
- Used as a standalone arithmetic unit inside the datapath.

Parameters:
- none (format fixed to binary32)

Ports:
- clk  input  1   system clock, rising-edge
- rst  input  1   asynchronous, active-low reset
- a    input  32  operand A, binary32
- b    input  32  operand B, binary32
- z    output 32  product, binary32, registered

Behaviour:
- Reset:
  - While rst=0, all pipeline registers clear asynchronously.
  - z = 32'h00000000 during reset.
  - On release, the pipeline refills; z is valid 4 rising edges after the first sampled operands.
- Latency and sampling:
  - a and b are sampled on every rising edge.
  - The result appears on z exactly 4 cycles later: S1 unpack/classify, S2 mantissa multiply, S3 normalise, S4 round/pack.
  - Throughput is 1 result per cycle.
  - Holding constant inputs keeps z constant after the pipeline fills.
- Unpack:
  - sign = a[31]^b[31]
  - exponent field = [30:23]
  - fraction = [22:0]
  - hidden bit = 1 for normal operands.
- Denormal inputs (exp=0, frac!=0) are flushed to zero before classification.
- Special cases, checked in priority order; each produces the listed result directly:
  1. Either operand NaN (exp=FF, frac!=0) -> z = 32'h7FC00000 (quiet NaN, sign 0).
  2. Either operand Inf (exp=FF, frac=0) -> z = {sign, 8'hFF, 23'h0}. This applies also when the other operand is zero: Inf*0 returns Inf, not NaN. This is a deliberate design choice.
  3. Either operand zero -> z = {sign, 31'h0}.
- Normal path:
  - 24x24 unsigned multiply produces a 48-bit product.
  - Biased exponent = ea + eb - 127, held in a 10-bit signed intermediate.
  - If product[47]=1: shift right by 1 and increment the exponent.
  - Rounding is round-to-nearest-even, using guard, round and sticky bits (sticky = OR of all lower bits).
  - A mantissa carry-out from rounding renormalises and increments the exponent.
- Range handling:
  - Final exponent >= 255 -> overflow to {sign, 8'hFF, 23'h0}.
  - Final exponent <= 0 -> underflow, flushed to {sign, 31'h0}. No denormal outputs.
- Reset asserted mid-operation discards all in-flight results.

Decomposition:
- Package fp32_pkg holds:
  - field widths (EXP_W=8, FRAC_W=23) and BIAS=127
  - constants QNAN=32'h7FC00000, EXP_MAX=8'hFF
  - a classify typedef: enum ZERO, NORMAL, INF, NAN
- One natural sub-module: fp32_round_pack, covering normalise, RNE, overflow/underflow and pack.
- The remaining logic stays in float_multi.

Test Plan:
- 0.3*0.3: a=b=32'h3E99999A held -> z=32'h3DB851EC after 4 cycles.
- Inf*0: a=32'h7F800000, b=32'h00000000 -> z=32'h7F800000.
- Inf*Inf: a=b=32'h7F800000 -> z=32'h7F800000.
- NaN*valid: a=32'h7FC00000, b=32'h3E000000 -> z=32'h7FC00000 (exp=FF, frac!=0).
- Sign/overflow/underflow:
  - a=32'hC0000000 (-2.0), b=32'h40400000 (3.0) -> z=32'hC0C00000.
  - a=b=32'h7F000000 -> z=32'h7F800000.
  - a=b=32'h00800000 -> z=32'h00000000.
- Reset and pipelining:
  - Assert rst=0 mid-stream -> z=0 immediately.
  - Release with back-to-back distinct operands each cycle -> each result appears exactly 4 cycles after its inputs, in order.
